// File: rtl/digital_bit_buffer_pkg.sv
// Shared constants and state encoding for the serial bit buffer feeding the 12-bit word packer.
package digital_bit_buffer_pkg;

  localparam int unsigned DEPTH = 10240;
  localparam int unsigned AW    = 14;
  localparam int unsigned CW    = 15;
  localparam int unsigned SYNC  = 3;

  typedef enum logic [1:0] {
    StFill  = 2'd0,
    StFull  = 2'd1,
    StDrain = 2'd2
  } bufState_e;

  function automatic logic stateBusy(input bufState_e s);
    return (s == StFull) || (s == StDrain);
  endfunction

endpackage

// File: rtl/bit_ram_1bit.sv
// Single-clock simple dual-port DEPTH x 1 RAM with registered read, written to map onto block RAM.
module bit_ram_1bit #(
  parameter int unsigned DEPTH = 10240,
  parameter int unsigned AW    = 14
) (
  input  logic          clk,
  input  logic          wrEn,
  input  logic [AW-1:0] wrAddr,
  input  logic          wrData,
  input  logic          rdEn,
  input  logic [AW-1:0] rdAddr,
  output logic          rdData
);

  // No reset on the array or read register so the tools can infer block RAM.
  logic mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
    if (rdEn) begin
      rdData <= mem[rdAddr];
    end
  end

endmodule

// File: rtl/digital_bit_buffer.sv
// Captures an asynchronous sclk/sdata stream into a DEPTH-bit buffer, then serves it one bit per
// bitRequest rising edge (first-word-fall-through) before clearing and refilling.
module digital_bit_buffer #(
  parameter int unsigned DEPTH = digital_bit_buffer_pkg::DEPTH,
  parameter int unsigned AW    = digital_bit_buffer_pkg::AW,
  parameter int unsigned CW    = digital_bit_buffer_pkg::CW,
  parameter int unsigned SYNC  = digital_bit_buffer_pkg::SYNC
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          sclk,
  input  logic          sdata,
  input  logic          bitRequest,
  output logic          bitData,
  output logic [CW-1:0] bitsUsed,
  output logic [CW-1:0] dropCount,
  output logic          busy
);
  import digital_bit_buffer_pkg::*;

  localparam logic [CW-1:0] DepthCw = CW'(DEPTH);
  localparam logic [CW-1:0] DropMax = '1;

  logic [SYNC-1:0] sclkSync;
  // sdata is sampled at the stage matching sclkSync[SYNC-2], so its final stage would be unused.
  logic [SYNC-2:0] sdataSync;
  logic            bitRequestQ;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sclkSync    <= '0;
      sdataSync   <= '0;
      bitRequestQ <= 1'b0;
    end else begin
      sclkSync[0]  <= sclk;
      sdataSync[0] <= sdata;
      for (int i = 1; i < SYNC; i++) begin
        sclkSync[i] <= sclkSync[i-1];
      end
      for (int i = 1; i < SYNC - 1; i++) begin
        sdataSync[i] <= sdataSync[i-1];
      end
      bitRequestQ <= bitRequest;
    end
  end

  logic sclkEdge;
  logic sample;
  logic pop;

  assign sclkEdge = sclkSync[SYNC-2] & ~sclkSync[SYNC-1];
  assign sample   = sdataSync[SYNC-2];
  assign pop      = bitRequest & ~bitRequestQ;

  bufState_e     state;
  logic [AW-1:0] wptr;
  logic [AW-1:0] rptr;
  logic [CW-1:0] bitsTaken;
  logic          rdValid;

  logic [CW-1:0] bitsUsedInc;
  logic [CW-1:0] bitsTakenInc;
  logic          drainPop;
  logic          lastPop;
  logic          wrEn;
  logic          rdEn;
  logic [AW-1:0] rdAddr;
  logic          ramData;

  always_comb begin
    bitsUsedInc  = bitsUsed + CW'(1);
    bitsTakenInc = bitsTaken + CW'(1);
    drainPop     = (state == StDrain) && pop;
    lastPop      = drainPop && (bitsTakenInc == DepthCw);
    wrEn         = (state == StFill) && sclkEdge;
    // The final pop issues no read: rptr + 1 would point past the buffer.
    rdEn         = (state == StFull) || (drainPop && !lastPop);
    rdAddr       = (state == StFull) ? '0 : rptr + AW'(1);
  end

  bit_ram_1bit #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) uRam (
    .clk   (clk),
    .wrEn  (wrEn),
    .wrAddr(wptr),
    .wrData(sample),
    .rdEn  (rdEn),
    .rdAddr(rdAddr),
    .rdData(ramData)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= StFill;
      wptr      <= '0;
      rptr      <= '0;
      bitsUsed  <= '0;
      bitsTaken <= '0;
      dropCount <= '0;
      busy      <= 1'b0;
      bitData   <= 1'b0;
      rdValid   <= 1'b0;
    end else begin
      rdValid <= rdEn;
      // Loading one cycle after the RAM register keeps bitData stable through the pop cycle.
      if (rdValid) begin
        bitData <= ramData;
      end

      if (sclkEdge && stateBusy(state) && (dropCount != DropMax)) begin
        dropCount <= dropCount + CW'(1);
      end

      case (state)
        StFill: begin
          if (sclkEdge) begin
            wptr     <= wptr + AW'(1);
            bitsUsed <= bitsUsedInc;
            if (bitsUsedInc == DepthCw) begin
              state <= StFull;
              busy  <= 1'b1;
            end
          end
        end
        StFull: begin
          state <= StDrain;
        end
        StDrain: begin
          if (lastPop) begin
            state     <= StFill;
            busy      <= 1'b0;
            bitsUsed  <= '0;
            bitsTaken <= '0;
            wptr      <= '0;
            rptr      <= '0;
          end else if (drainPop) begin
            bitsTaken <= bitsTakenInc;
            rptr      <= rptr + AW'(1);
          end
        end
        default: begin
          state <= StFill;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_digital_bit_buffer.sv
// Directed bench for digital_bit_buffer at a reduced DEPTH: fill, drain, drops, reset and overlaps.
module tb_digital_bit_buffer;

  localparam int unsigned DEPTH = 128;
  localparam int unsigned AW    = 7;
  localparam int unsigned CW    = 8;
  localparam int unsigned SYNC  = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          sclk;
  logic          sdata;
  logic          bitRequest;
  logic          bitData;
  logic [CW-1:0] bitsUsed;
  logic [CW-1:0] dropCount;
  logic          busy;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  digital_bit_buffer #(
    .DEPTH(DEPTH),
    .AW   (AW),
    .CW   (CW),
    .SYNC (SYNC)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sclk      (sclk),
    .sdata     (sdata),
    .bitRequest(bitRequest),
    .bitData   (bitData),
    .bitsUsed  (bitsUsed),
    .dropCount (dropCount),
    .busy      (busy)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // 0: 1,0,1,...  1: 0xA5 bytes MSB first  2: i[1]^i[4]  3: all ones
  function automatic logic patBit(input int p, input int i);
    logic [7:0]  a5;
    logic [31:0] iv;
    a5 = 8'hA5;
    iv = i;
    case (p)
      0:       return ~iv[0];
      1:       return a5[7 - (i % 8)];
      2:       return iv[1] ^ iv[4];
      default: return 1'b1;
    endcase
  endfunction

  task automatic sclkPulse(input logic d);
    sdata = d;
    sclk  = 1'b1;
    cyc();
    cyc();
    sclk = 1'b0;
    cyc();
    cyc();
  endtask

  task automatic fill(input int p, input int start, input int n);
    for (int k = 0; k < n; k++) begin
      sclkPulse(patBit(p, start + k));
    end
  endtask

  task automatic pop();
    bitRequest = 1'b1;
    cyc();
    bitRequest = 1'b0;
    cyc();
  endtask

  // simulIdx >= 0 lands an sclk edge in the same cycle as that pop.
  task automatic drain(input int p, input int simulIdx);
    for (int i = 0; i < DEPTH; i++) begin
      chk($sformatf("drain_p%0d_bit%0d", p, i), {31'd0, bitData}, {31'd0, patBit(p, i)});
      if (i == simulIdx) begin
        sdata = 1'b0;
        sclk  = 1'b1;
        cyc();
        cyc();
        pop();
        sclk = 1'b0;
      end else begin
        pop();
      end
      if (i == DEPTH - 1) begin
        chk("drain_end_used", 32'(bitsUsed), 32'd0);
        chk("drain_end_busy", {31'd0, busy}, 32'd0);
      end
      cyc();
      cyc();
    end
  endtask

  initial begin
    reset      = 1'b0;
    sclk       = 1'b0;
    sdata      = 1'b0;
    bitRequest = 1'b0;
    repeat (3) cyc();
    chk("reset_bitData", {31'd0, bitData}, 32'd0);
    chk("reset_used", 32'(bitsUsed), 32'd0);
    chk("reset_drop", 32'(dropCount), 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b1;
    cyc();

    // First fill, with pops injected at bitsUsed=100 that must be ignored.
    fill(0, 0, 100);
    chk("fill100_used", 32'(bitsUsed), 32'd100);
    chk("fill100_busy", {31'd0, busy}, 32'd0);
    repeat (3) begin
      pop();
      cyc();
      cyc();
    end
    chk("fillpop_bitData", {31'd0, bitData}, 32'd0);
    chk("fillpop_used", 32'(bitsUsed), 32'd100);
    fill(0, 100, DEPTH - 100);
    chk("full_used", 32'(bitsUsed), 32'(DEPTH));
    chk("full_busy", {31'd0, busy}, 32'd1);
    cyc();
    cyc();
    chk("full_head", {31'd0, bitData}, 32'd1);

    // Edges while draining are dropped and leave the buffer intact.
    repeat (5) sclkPulse(1'b0);
    chk("drop5_count", 32'(dropCount), 32'd5);
    chk("drop5_used", 32'(bitsUsed), 32'(DEPTH));
    drain(0, -1);
    chk("drop5_kept", 32'(dropCount), 32'd5);

    // Asynchronous reset mid-fill.
    fill(3, 0, 50);
    chk("fill50_used", 32'(bitsUsed), 32'd50);
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    chk("midrst_used", 32'(bitsUsed), 32'd0);
    chk("midrst_drop", 32'(dropCount), 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_bitData", {31'd0, bitData}, 32'd0);
    cyc();
    reset = 1'b1;
    cyc();

    // Refill with 0xA5 bytes; one pop shares its cycle with an sclk edge.
    fill(1, 0, DEPTH);
    chk("a5_used", 32'(bitsUsed), 32'(DEPTH));
    cyc();
    cyc();
    drain(1, 10);
    chk("simul_drop", 32'(dropCount), 32'd1);

    // Fresh pattern, clean cycle.
    fill(2, 0, DEPTH);
    chk("p2_busy", {31'd0, busy}, 32'd1);
    cyc();
    cyc();
    drain(2, -1);
    chk("p2_drop", 32'(dropCount), 32'd1);

    // Drop counter saturation while holding a full buffer.
    fill(3, 0, DEPTH);
    cyc();
    cyc();
    repeat (260) sclkPulse(1'b0);
    chk("sat_drop", 32'(dropCount), 32'd255);
    chk("sat_head", {31'd0, bitData}, 32'd1);
    chk("sat_used", 32'(bitsUsed), 32'(DEPTH));
    chk("sat_busy", {31'd0, busy}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
